// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// State encoding, funct3 operation codes and the iteration-counter width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Counter must reach XLEN-1 and still compare cleanly against it.
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_diff;

    // Shifted remainder is below 2*divisor, so bit XLEN of the difference is a clean sign.
    assign w_diff = i_rem - {1'b0, i_div};
    assign o_qbit = ~w_diff[XLEN];
    assign o_rem  = o_qbit ? w_diff[XLEN-1:0] : i_rem[XLEN-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply or restoring
// divide at one bit per cycle, with a start/stall/done pipeline handshake.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallReqE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int CW = cnt_width(XLEN);
    localparam logic [XLEN-1:0]   ZERO  = '0;
    localparam logic [XLEN-1:0]   ONES  = '1;
    localparam logic [XLEN-1:0]   MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO2 = '0;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN:0]   r_acc;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_val;
    logic [XLEN-1:0]   r_result;
    logic              r_busy;
    logic              r_done;

    // Acceptance-time decode
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_spec;
    logic [XLEN-1:0] w_spec_val;

    assign w_accept   = (r_state == IDLE) & StartE & ~FlushE;
    assign w_is_div   = funct3E[2];
    assign w_a_signed = (funct3E == F3_MULH) | (funct3E == F3_MULHSU) |
                        (funct3E == F3_DIV)  | (funct3E == F3_REM);
    assign w_b_signed = (funct3E == F3_MULH) | (funct3E == F3_DIV) | (funct3E == F3_REM);
    assign w_a_neg    = w_a_signed & SrcAE[XLEN-1];
    assign w_b_neg    = w_b_signed & SrcBE[XLEN-1];
    // |MIN| wraps to the bit pattern 2^(XLEN-1), which is correct read as unsigned.
    assign w_a_mag    = w_a_neg ? (ZERO - SrcAE) : SrcAE;
    assign w_b_mag    = w_b_neg ? (ZERO - SrcBE) : SrcBE;
    assign w_div_zero = w_is_div & (SrcBE == ZERO);
    assign w_ovf      = ((funct3E == F3_DIV) | (funct3E == F3_REM)) &
                        (SrcAE == MIN) & (SrcBE == ONES);
    assign w_spec     = w_div_zero | w_ovf;
    assign w_spec_val = w_div_zero ? (funct3E[1] ? SrcAE : ONES)
                                   : (funct3E[1] ? ZERO  : MIN);

    // Multiply step: add multiplicand into the high half, then shift right.
    logic            w_mul_bit;
    logic [XLEN-1:0] w_mul_add;
    logic [XLEN:0]   w_mul_hi;
    logic [2*XLEN:0] w_mul_next;

    assign w_mul_bit  = r_b[r_cnt[CW-2:0]];
    assign w_mul_add  = w_mul_bit ? r_a : ZERO;
    assign w_mul_hi   = r_acc[2*XLEN:XLEN] + {1'b0, w_mul_add};
    assign w_mul_next = {1'b0, w_mul_hi, r_acc[XLEN-1:1]};

    // Divide step: accumulator holds {remainder, dividend/quotient}.
    logic [XLEN-1:0] w_step_rem;
    logic            w_step_q;
    logic [2*XLEN:0] w_div_next;

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .i_rem  (r_acc[2*XLEN-1:XLEN-1]),
        .i_div  (r_b),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    assign w_div_next = {1'b0, w_step_rem, r_acc[XLEN-2:0], w_step_q};

    // Sign correction and half selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_val;

    assign w_prod = r_neg_res ? (ZERO2 - r_acc[2*XLEN-1:0]) : r_acc[2*XLEN-1:0];
    assign w_quot = r_neg_res ? (ZERO - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_rem ? (ZERO - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_val = ZERO;
        case (r_op)
            F3_MUL:                       w_fix_val = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_val = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_fix_val = w_quot;
            default:                      w_fix_val = w_rem;
        endcase
        if (r_spec) begin
            w_fix_val = r_spec_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= funct3E;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_a        <= w_a_mag;
                        r_b        <= w_b_mag;
                        r_acc      <= w_is_div ? {{(XLEN+1){1'b0}}, w_a_mag} : '0;
                        r_cnt      <= '0;
                        r_spec     <= w_spec;
                        r_spec_val <= w_spec_val;
                        r_busy     <= 1'b1;
                        if (FAST_SPECIAL && w_spec) begin
                            r_state <= FIX;
                        end else begin
                            r_state <= w_is_div ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (FlushE) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= (r_state == DIV) ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    r_busy <= 1'b0;
                    if (FlushE) begin
                        r_state <= IDLE;
                    end else begin
                        r_result <= w_fix_val;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign StallReqE = w_accept | r_busy;
    assign BusyE     = r_busy;
    assign DoneE     = r_done;
    assign ResultE   = r_result;

endmodule
